// File: rtl/i2c_slave_target_if.sv
// Bus-side and user-side signal bundle for the I2C target.
interface i2c_slave_target_if #(
  parameter int unsigned DATA_SIZE = 8
);
  logic                 scl_i;
  logic                 sda_i;
  logic                 sda_oe_o;
  logic                 start_o;
  logic                 stop_o;
  logic                 addr_match_o;
  logic                 rw_o;
  logic [DATA_SIZE-1:0] rx_data_o;
  logic                 rx_valid_o;
  logic [DATA_SIZE-1:0] tx_data_i;
  logic                 tx_req_o;

  modport slave (
    input  scl_i, sda_i, tx_data_i,
    output sda_oe_o, start_o, stop_o, addr_match_o, rw_o,
           rx_data_o, rx_valid_o, tx_req_o
  );

  modport master (
    output scl_i, sda_i, tx_data_i,
    input  sda_oe_o, start_o, stop_o, addr_match_o, rw_o,
           rx_data_o, rx_valid_o, tx_req_o
  );
endinterface

// File: rtl/i2c_slave_target.sv
// I2C target: oversampled SCL/SDA, fixed 7-bit address, open-drain SDA, no clock stretching.
module i2c_slave_target #(
  parameter int unsigned DATA_SIZE  = 8,
  parameter logic [6:0]  SLAVE_ADDR = 7'h3C
) (
  input logic            i2c_core_clk_i,
  input logic            i2c_core_rst_i,
  i2c_slave_target_if.slave bus
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_SIZE - 1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK = 3'd2;
  localparam logic [2:0] ST_WR_DATA  = 3'd3;
  localparam logic [2:0] ST_WR_ACK   = 3'd4;
  localparam logic [2:0] ST_RD_DATA  = 3'd5;
  localparam logic [2:0] ST_RD_ACK   = 3'd6;
  localparam logic [2:0] ST_WAIT_END = 3'd7;

  logic scl_meta_q, scl_meta_d, scl_sync_q, scl_sync_d, scl_hist_q, scl_hist_d;
  logic sda_meta_q, sda_meta_d, sda_sync_q, sda_sync_d, sda_hist_q, sda_hist_d;

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_SIZE-2:0] shift_q, shift_d;
  logic [DATA_SIZE-1:0] tx_byte_q, tx_byte_d;
  logic [DATA_SIZE-1:0] rx_data_q, rx_data_d;
  logic                 sda_oe_q, sda_oe_d;
  logic                 start_q, start_d;
  logic                 stop_q, stop_d;
  logic                 addr_match_q, addr_match_d;
  logic                 rw_q, rw_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 tx_req_q, tx_req_d;

  logic                 scl_rise_c, scl_fall_c, start_det_c, stop_det_c;
  logic [DATA_SIZE-1:0] shift_in_c;

  // Synchronizer next-state: two stages plus a history flop per line
  always_comb begin
    scl_meta_d = bus.scl_i;
    scl_sync_d = scl_meta_q;
    scl_hist_d = scl_sync_q;
    sda_meta_d = bus.sda_i;
    sda_sync_d = sda_meta_q;
    sda_hist_d = sda_sync_q;
  end

  // Synchronizer flops; reset to the idle-bus level so release never looks like an event
  always_ff @(posedge i2c_core_clk_i or posedge i2c_core_rst_i) begin
    if (i2c_core_rst_i) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_hist_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_meta_d;
      scl_sync_q <= scl_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_meta_q <= sda_meta_d;
      sda_sync_q <= sda_sync_d;
      sda_hist_q <= sda_hist_d;
    end
  end

  // Edge and bus-condition detection on synchronized lines
  always_comb begin
    scl_rise_c  = scl_sync_q & ~scl_hist_q;
    scl_fall_c  = ~scl_sync_q & scl_hist_q;
    start_det_c = scl_sync_q & scl_hist_q & sda_hist_q & ~sda_sync_q;
    stop_det_c  = scl_sync_q & scl_hist_q & ~sda_hist_q & sda_sync_q;
    shift_in_c  = {shift_q, sda_sync_q};
  end

  // Protocol FSM: bus events override any SCL edge in the same cycle
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    tx_byte_d    = tx_byte_q;
    rx_data_d    = rx_data_q;
    sda_oe_d     = sda_oe_q;
    addr_match_d = addr_match_q;
    rw_d         = rw_q;
    start_d      = 1'b0;
    stop_d       = 1'b0;
    rx_valid_d   = 1'b0;
    tx_req_d     = 1'b0;

    if (start_det_c) begin
      state_d      = ST_ADDR;
      cnt_d        = '0;
      sda_oe_d     = 1'b0;
      addr_match_d = 1'b0;
      start_d      = 1'b1;
    end else if (stop_det_c) begin
      state_d      = ST_IDLE;
      cnt_d        = '0;
      sda_oe_d     = 1'b0;
      addr_match_d = 1'b0;
      stop_d       = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_WAIT_END: begin
          state_d = state_q;
        end
        ST_ADDR: begin
          if (scl_rise_c) begin
            shift_d = shift_in_c[DATA_SIZE-2:0];
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
              cnt_d = '0;
              // General-call address 0 is never acknowledged
              if ((shift_in_c[DATA_SIZE-1:1] == SLAVE_ADDR) && (shift_in_c[DATA_SIZE-1:1] != 7'd0)) begin
                rw_d    = shift_in_c[0];
                state_d = ST_ADDR_ACK;
              end else begin
                state_d = ST_WAIT_END;
              end
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall_c) begin
            if (cnt_q == '0) begin
              sda_oe_d     = 1'b1;
              addr_match_d = 1'b1;
              cnt_d        = CNT_W'(1);
            end else begin
              cnt_d = '0;
              if (!rw_q) begin
                sda_oe_d = 1'b0;
                state_d  = ST_WR_DATA;
              end else begin
                tx_byte_d = bus.tx_data_i;
                tx_req_d  = 1'b1;
                sda_oe_d  = ~bus.tx_data_i[DATA_SIZE-1];
                state_d   = ST_RD_DATA;
              end
            end
          end
        end
        ST_WR_DATA: begin
          if (scl_rise_c) begin
            shift_d = shift_in_c[DATA_SIZE-2:0];
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
              rx_data_d  = shift_in_c;
              rx_valid_d = 1'b1;
              cnt_d      = '0;
              state_d    = ST_WR_ACK;
            end
          end
        end
        ST_WR_ACK: begin
          if (scl_fall_c) begin
            if (cnt_q == '0) begin
              sda_oe_d = 1'b1;
              cnt_d    = CNT_W'(1);
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              state_d  = ST_WR_DATA;
            end
          end
        end
        ST_RD_DATA: begin
          // MSB went out on entry; each falling edge presents the next bit, the 8th ends the byte
          if (scl_fall_c) begin
            if (cnt_q == LAST_BIT) begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              state_d  = ST_RD_ACK;
            end else begin
              sda_oe_d = ~tx_byte_q[CNT_W'(LAST_BIT - CNT_W'(1) - cnt_q)];
              cnt_d    = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise_c) begin
            if (sda_sync_q) begin
              cnt_d   = '0;
              state_d = ST_WAIT_END;
            end else begin
              cnt_d = CNT_W'(1);
            end
          end else if (scl_fall_c && (cnt_q == CNT_W'(1))) begin
            tx_byte_d = bus.tx_data_i;
            tx_req_d  = 1'b1;
            sda_oe_d  = ~bus.tx_data_i[DATA_SIZE-1];
            cnt_d     = '0;
            state_d   = ST_RD_DATA;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FSM and output registers; asynchronous reset releases SDA immediately
  always_ff @(posedge i2c_core_clk_i or posedge i2c_core_rst_i) begin
    if (i2c_core_rst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      tx_byte_q    <= '0;
      rx_data_q    <= '0;
      sda_oe_q     <= 1'b0;
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
      addr_match_q <= 1'b0;
      rw_q         <= 1'b0;
      rx_valid_q   <= 1'b0;
      tx_req_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      tx_byte_q    <= tx_byte_d;
      rx_data_q    <= rx_data_d;
      sda_oe_q     <= sda_oe_d;
      start_q      <= start_d;
      stop_q       <= stop_d;
      addr_match_q <= addr_match_d;
      rw_q         <= rw_d;
      rx_valid_q   <= rx_valid_d;
      tx_req_q     <= tx_req_d;
    end
  end

  assign bus.sda_oe_o     = sda_oe_q;
  assign bus.start_o      = start_q;
  assign bus.stop_o       = stop_q;
  assign bus.addr_match_o = addr_match_q;
  assign bus.rw_o         = rw_q;
  assign bus.rx_data_o    = rx_data_q;
  assign bus.rx_valid_o   = rx_valid_q;
  assign bus.tx_req_o     = tx_req_q;

endmodule

// File: tb/tb_i2c_slave_target.sv
// Scoreboard bench for i2c_slave_target: bit-banged master, queued expectations, decoupled monitor.
module tb_i2c_slave_target;

  logic clk = 1'b0;
  logic rst;
  logic scl_m, sda_m;

  always #5 clk = ~clk;

  i2c_slave_target_if #(.DATA_SIZE(8)) bus_if ();

  assign bus_if.scl_i = scl_m;
  assign bus_if.sda_i = sda_m & ~bus_if.sda_oe_o;

  i2c_slave_target #(.DATA_SIZE(8), .SLAVE_ADDR(7'h3C)) dut (
    .i2c_core_clk_i (clk),
    .i2c_core_rst_i (rst),
    .bus            (bus_if.slave)
  );

  int checks = 0;
  int errors = 0;
  int n_start, n_stop, n_rx, n_tx, n_oe, n_am;

  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_rd_q[$];
  logic [7:0] obs_rd_q[$];
  logic [7:0] tx_src_q[$];
  logic       exp_ack_q[$];
  logic       obs_ack_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic clear_counts();
    n_start = 0; n_stop = 0; n_rx = 0; n_tx = 0; n_oe = 0; n_am = 0;
  endtask

  // Master bus primitives: SDA only moves while SCL is low, except for START/STOP
  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(4);
    scl_m = 1'b1; wait_clk(8);
    sda_m = 1'b0; wait_clk(8);
    scl_m = 1'b0; wait_clk(4);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(4);
    scl_m = 1'b1; wait_clk(8);
    sda_m = 1'b1; wait_clk(8);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; wait_clk(4);
    scl_m = 1'b1; wait_clk(8);
    scl_m = 1'b0; wait_clk(4);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_clk(4);
    scl_m = 1'b1; wait_clk(4);
    b = bus_if.sda_i; wait_clk(4);
    scl_m = 1'b0; wait_clk(4);
  endtask

  task automatic write_byte(input logic [7:0] d);
    logic a;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(a);
    obs_ack_q.push_back(a);
  endtask

  task automatic read_byte(input logic master_ack);
    logic [7:0] d;
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(master_ack);
    obs_rd_q.push_back(d);
  endtask

  // Monitor: counts pulses, pops scoreboard entries whenever the DUT or master produces an observation
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.start_o) n_start++;
      if (bus_if.stop_o) n_stop++;
      if (bus_if.sda_oe_o) n_oe++;
      if (bus_if.addr_match_o) n_am++;
      if (bus_if.rx_valid_o) begin
        n_rx++;
        if (exp_rx_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rx_unexpected: got 0x%0h expected no rx_valid", bus_if.rx_data_o);
        end else check("rx_data", 32'(bus_if.rx_data_o), 32'(exp_rx_q.pop_front()));
      end
      if (bus_if.tx_req_o) begin
        n_tx++;
        if (tx_src_q.size() > 0) bus_if.tx_data_i = tx_src_q.pop_front();
      end
      while (obs_ack_q.size() > 0) begin
        logic a;
        a = obs_ack_q.pop_front();
        if (exp_ack_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ack_unexpected: got %0b expected no ack slot", a);
        end else check("ack_bit", 32'(a), 32'(exp_ack_q.pop_front()));
      end
      while (obs_rd_q.size() > 0) begin
        logic [7:0] d;
        d = obs_rd_q.pop_front();
        if (exp_rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected: got 0x%0h expected no read byte", d);
        end else check("rd_byte", 32'(d), 32'(exp_rd_q.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  function automatic logic [14:0] out_vec();
    return {bus_if.sda_oe_o, bus_if.start_o, bus_if.stop_o, bus_if.addr_match_o,
            bus_if.rw_o, bus_if.rx_valid_o, bus_if.tx_req_o, bus_if.rx_data_o};
  endfunction

  initial begin
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; bus_if.tx_data_i = 8'h00;
    clear_counts();
    wait_clk(4);
    @(negedge clk);
    check("reset_outputs", 32'(out_vec()), 32'h0);
    rst = 1'b0;
    wait_clk(4);

    // Write: addr 0x3C W, 0xA5, 0x5A
    clear_counts();
    exp_ack_q.push_back(1'b0); exp_ack_q.push_back(1'b0); exp_ack_q.push_back(1'b0);
    exp_rx_q.push_back(8'hA5); exp_rx_q.push_back(8'h5A);
    i2c_start();
    write_byte(8'h78);
    check("wr_rw", 32'(bus_if.rw_o), 32'h0);
    check("wr_addr_match", 32'(bus_if.addr_match_o), 32'h1);
    write_byte(8'hA5);
    write_byte(8'h5A);
    i2c_stop();
    wait_clk(6);
    check("wr_n_start", 32'(n_start), 32'd1);
    check("wr_n_stop", 32'(n_stop), 32'd1);
    check("wr_n_rx", 32'(n_rx), 32'd2);
    check("wr_am_after_stop", 32'(bus_if.addr_match_o), 32'h0);

    // Read: 0xC3 ACKed, 0x3C NACKed
    clear_counts();
    bus_if.tx_data_i = 8'hC3;
    tx_src_q.push_back(8'h3C);
    exp_ack_q.push_back(1'b0);
    exp_rd_q.push_back(8'hC3); exp_rd_q.push_back(8'h3C);
    i2c_start();
    write_byte(8'h79);
    check("rd_rw", 32'(bus_if.rw_o), 32'h1);
    read_byte(1'b0);
    read_byte(1'b1);
    @(negedge clk);
    check("rd_released_after_nack", 32'(bus_if.sda_oe_o), 32'h0);
    i2c_stop();
    wait_clk(6);
    check("rd_n_tx", 32'(n_tx), 32'd2);
    check("rd_n_stop", 32'(n_stop), 32'd1);

    // Address mismatch 0x50 plus general call 0x00
    clear_counts();
    exp_ack_q.push_back(1'b1); exp_ack_q.push_back(1'b1); exp_ack_q.push_back(1'b1);
    i2c_start();
    write_byte(8'h50);
    write_byte(8'h12);
    write_byte(8'h34);
    i2c_stop();
    exp_ack_q.push_back(1'b1);
    i2c_start();
    write_byte(8'h00);
    i2c_stop();
    wait_clk(6);
    check("mm_n_oe", 32'(n_oe), 32'd0);
    check("mm_n_rx", 32'(n_rx), 32'd0);
    check("mm_n_tx", 32'(n_tx), 32'd0);
    check("mm_n_am", 32'(n_am), 32'd0);
    check("mm_n_start", 32'(n_start), 32'd2);

    // Repeated START: write 0x11 then read 0xEE
    clear_counts();
    bus_if.tx_data_i = 8'hEE;
    exp_ack_q.push_back(1'b0); exp_ack_q.push_back(1'b0); exp_ack_q.push_back(1'b0);
    exp_rx_q.push_back(8'h11);
    exp_rd_q.push_back(8'hEE);
    i2c_start();
    write_byte(8'h78);
    check("rs_rw_write", 32'(bus_if.rw_o), 32'h0);
    write_byte(8'h11);
    i2c_start();
    write_byte(8'h79);
    check("rs_rw_read", 32'(bus_if.rw_o), 32'h1);
    read_byte(1'b1);
    i2c_stop();
    wait_clk(6);
    check("rs_n_start", 32'(n_start), 32'd2);
    check("rs_rx_data", 32'(bus_if.rx_data_o), 32'h11);
    check("rs_n_tx", 32'(n_tx), 32'd1);

    // Reset while driving the address ACK
    clear_counts();
    exp_ack_q.push_back(1'b0);
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(1'(8'h78 >> i));
    sda_m = 1'b1; wait_clk(4);
    scl_m = 1'b1; wait_clk(3);
    @(negedge clk);
    check("rst_oe_before", 32'(bus_if.sda_oe_o), 32'h1);
    #2 rst = 1'b1;
    #1 check("rst_outputs_async", 32'(out_vec()), 32'h0);
    wait_clk(3);
    rst = 1'b0;
    wait_clk(2);
    scl_m = 1'b0; wait_clk(4);
    i2c_start();
    write_byte(8'h78);
    check("rst_re_addr_match", 32'(bus_if.addr_match_o), 32'h1);
    i2c_stop();
    wait_clk(6);

    // Abort: STOP after 4 bits of a write data byte
    clear_counts();
    exp_ack_q.push_back(1'b0);
    i2c_start();
    write_byte(8'h78);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    i2c_stop();
    wait_clk(6);
    check("ab_n_rx", 32'(n_rx), 32'd0);
    check("ab_n_stop", 32'(n_stop), 32'd1);
    check("ab_state_idle", 32'(dut.state_q), 32'd0);
    check("ab_addr_match", 32'(bus_if.addr_match_o), 32'h0);

    wait_clk(4);
    check("exp_ack_drained", 32'(exp_ack_q.size()), 32'd0);
    check("exp_rx_drained", 32'(exp_rx_q.size()), 32'd0);
    check("exp_rd_drained", 32'(exp_rd_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
